sc_eval_sequencer: RTL and testbench

Sequencer that drives one stochastic-computing `circuit` instance through a sweep of binary operand values. It owns the feedback registers that close the circuit's state loop (`output_s`→`input_s`, `out_x_i`→`in_x_i`), steps `input_b`, and counts ones on `output_circuit` over a fixed stream length per operand. It emits one result per operand on a valid/ready port. It replaces free-running bench timing with a deterministic, restartable controller in the SC evaluation path.

---
 rtl/sc_eval_sequencer.sv | 116 +++++++++++
 tb/tb_sc_eval_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_eval_sequencer.sv
// Sequencer that sweeps a binary operand through a stochastic-computing circuit,
// closing its state loop and counting output ones over a fixed stream per operand.
module sc_eval_sequencer #(
  parameter int WIDTH      = 8,
  parameter int STREAM_LEN = 255,
  parameter int SEED       = 1,
  parameter int NUM_X      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] b_first,
  input  logic [WIDTH-1:0] b_last,
  output logic [WIDTH-1:0] cir_input_s,
  input  logic [WIDTH-1:0] cir_output_s,
  output logic [WIDTH-1:0] cir_input_b,
  output logic [NUM_X-1:0] cir_in_x,
  input  logic [NUM_X-1:0] cir_out_x,
  input  logic             cir_output_circuit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_b,
  output logic [WIDTH-1:0] res_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_REPORT,
    S_FINISH
  } state_t;

  localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] LAST_CYC = WIDTH'(STREAM_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] b_last_q;
  logic [WIDTH-1:0] ones_cnt;
  logic [WIDTH-1:0] cyc_cnt;
  logic [WIDTH-1:0] ones_nxt;
  logic             last_cyc;
  logic             last_op;

  assign last_cyc = (cyc_cnt == LAST_CYC);
  assign last_op  = (cir_input_b == b_last_q);
  assign ones_nxt = ones_cnt + WIDTH'(cir_output_circuit);

  assign res_valid = (state == S_REPORT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SEED;
      S_SEED:   state_nxt = S_RUN;
      S_RUN:    if (last_cyc) state_nxt = S_REPORT;
      S_REPORT: if (res_ready) state_nxt = last_op ? S_FINISH : S_SEED;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The final RUN cycle's ones bit is folded straight into the latched result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cir_input_s <= SEED_V;
      cir_input_b <= '0;
      cir_in_x    <= '0;
      b_last_q    <= '0;
      ones_cnt    <= '0;
      cyc_cnt     <= '0;
      res_b       <= '0;
      res_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cir_input_b <= b_first;
            b_last_q    <= b_last;
          end
        end
        S_SEED: begin
          cir_input_s <= SEED_V;
          cir_in_x    <= '0;
          ones_cnt    <= '0;
          cyc_cnt     <= '0;
        end
        S_RUN: begin
          ones_cnt    <= ones_nxt;
          cyc_cnt     <= cyc_cnt + WIDTH'(1);
          cir_input_s <= cir_output_s;
          cir_in_x    <= cir_out_x;
          if (last_cyc) begin
            res_b     <= cir_input_b;
            res_count <= ones_nxt;
          end
        end
        S_REPORT: begin
          if (res_ready && !last_op) cir_input_b <= cir_input_b + WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_eval_sequencer.sv
// Bench for sc_eval_sequencer: stub LFSR circuit, queue scoreboard fed at start,
// and a negedge monitor that pops on every accepted result.
module tb_sc_eval_sequencer;

  localparam int L = 255;

  typedef struct {
    int b;
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] b_first = '0;
  logic [7:0] b_last = '0;
  logic [7:0] cir_input_s;
  logic [7:0] cir_output_s;
  logic [7:0] cir_input_b;
  logic [2:0] cir_in_x;
  logic [2:0] cir_out_x;
  logic       cir_output_circuit;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_b;
  logic [7:0] res_count;
  logic       busy;
  logic       done;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  bit   ready_random = 1'b0;
  bit   ready_force = 1'b1;
  exp_t exp_q[$];

  sc_eval_sequencer #(.WIDTH(8), .STREAM_LEN(L), .SEED(1), .NUM_X(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .b_first(b_first), .b_last(b_last),
    .cir_input_s(cir_input_s), .cir_output_s(cir_output_s), .cir_input_b(cir_input_b),
    .cir_in_x(cir_in_x), .cir_out_x(cir_out_x), .cir_output_circuit(cir_output_circuit),
    .res_valid(res_valid), .res_ready(res_ready), .res_b(res_b), .res_count(res_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Ones in the first L states of the stub's state sequence that fall below b.
  function automatic int model_count(input int b);
    logic [7:0] s;
    int c;
    s = 8'd1;
    c = 0;
    for (int i = 0; i < L; i++) begin
      if (int'(s) < b) c++;
      s = lfsr_next(s);
    end
    return c;
  endfunction

  assign cir_output_s       = lfsr_next(cir_input_s);
  assign cir_output_circuit = (cir_input_s < cir_input_b);
  assign cir_out_x          = {cir_in_x[1:0], cir_in_x[2]};

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    res_ready = ready_random ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: pops on handshake, checks result stability while back-pressured.
  bit         hold_pending = 1'b0;
  logic [7:0] held_b, held_count;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && res_valid) begin
      if (hold_pending) begin
        checkOutput("hold_res_b", int'(res_b), int'(held_b));
        checkOutput("hold_res_count", int'(res_count), int'(held_count));
      end
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result_b", int'(res_b), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("res_b", int'(res_b), e.b);
          checkOutput("res_count", int'(res_count), e.cnt);
        end
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held_b       = res_b;
        held_count   = res_count;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] first, input logic [7:0] last, input bit push);
    logic [7:0] b;
    if (push) begin
      b = first;
      forever begin
        exp_q.push_back('{b: int'(b), cnt: model_count(int'(b))});
        if (b == last) break;
        b = b + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    b_first = first;
    b_last  = last;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    b_first = 8'($urandom);
    b_last  = 8'($urandom);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    checkOutput("done_seen", int'(done), 1);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    checkOutput("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int sweeps;
    logic [7:0] s_snap;
    logic [7:0] f;
    sweeps = 0;

    // Reset state after a long idle stretch.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_input_s", int'(cir_input_s), 1);
    checkOutput("rst_input_b", int'(cir_input_b), 0);
    checkOutput("rst_in_x", int'(cir_in_x), 0);
    checkOutput("rst_res_valid", int'(res_valid), 0);
    checkOutput("rst_res_b", int'(res_b), 0);
    checkOutput("rst_res_count", int'(res_count), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);

    // Single operand 128: latency of res_valid and done.
    ready_force = 1'b1;
    applyStimulus(8'd128, 8'd128, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 600);
    checkOutput("valid_latency", n, L + 2);
    @(negedge clk);
    checkOutput("done_after_handshake", int'(done), 1);
    checkOutput("busy_with_done", int'(busy), 1);
    @(negedge clk);
    checkOutput("done_pulse_width", int'(done), 0);
    checkOutput("busy_falls", int'(busy), 0);
    sweeps++;
    checkOutput("done_count_single", done_cnt, sweeps);

    // Sweep 0..3, then 255 alone.
    applyStimulus(8'd0, 8'd3, 1'b1);
    waitDone(4 * (L + 2) + 20);
    sweeps++;
    applyStimulus(8'd255, 8'd255, 1'b1);
    waitDone(L + 20);
    sweeps++;

    // Wrapping sweep with random back-pressure.
    ready_random = 1'b1;
    applyStimulus(8'd254, 8'd1, 1'b1);
    waitDone(4 * (L + 40) + 50);
    sweeps++;
    checkOutput("done_count_wrap", done_cnt, sweeps);
    ready_random = 1'b0;

    // Deterministic back-pressure: 10 cycles with res_ready low.
    ready_force = 1'b0;
    applyStimulus(8'd10, 8'd11, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 600);
    s_snap = cir_input_s;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_valid_held", int'(res_valid), 1);
      checkOutput("bp_state_frozen", int'(cir_input_s), int'(s_snap));
    end
    ready_force = 1'b1;
    @(negedge clk);
    checkOutput("bp_valid_at_ready", int'(res_valid), 1);
    @(negedge clk);
    checkOutput("bp_proceeds", int'(res_valid), 0);
    checkOutput("bp_busy", int'(busy), 1);
    waitDone(L + 40);
    sweeps++;

    // Reset during RUN: partial result must be discarded.
    applyStimulus(8'd77, 8'd77, 1'b0);
    repeat (101) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_valid", int'(res_valid), 0);
    checkOutput("midrst_input_s", int'(cir_input_s), 1);
    checkOutput("midrst_res_count", int'(res_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fresh run; a start pulse while busy must be ignored.
    applyStimulus(8'd128, 8'd128, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    b_first = 8'd5;
    b_last  = 8'd9;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(L + 40);
    sweeps++;
    checkOutput("done_count_after_reset", done_cnt, sweeps);

    // Randomized short sweeps with random back-pressure.
    ready_random = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int span;
      f    = 8'($urandom_range(0, 255));
      span = $urandom_range(0, 2);
      applyStimulus(f, f + 8'(span), 1'b1);
      waitDone((span + 1) * (L + 40) + 50);
      sweeps++;
    end
    checkOutput("done_count_final", done_cnt, sweeps);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
